mod_p_reducer: RTL and testbench
================================

// Module: mod_p_reducer
// PURPOSE
//  Consumes the 2*WIDTH-bit product of the Booth multiplier and returns ab mod P, fully reduced.
//  - Bit-serial interleaved reduction, MSB first.
//  - Sits directly downstream of the multiplier in the field-multiply path.
//  - Valid/ready on both sides, so the multiplier's done/ab can drive in_valid/ab directly.
// PARAMETERS
//  WIDTH  P_WIDTH (377)  field element width; P must be < 2**WIDTH
//  P      params.p       modulus (BLS12-377 base field by default)
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-low; sampled on clk
//  ab         in   2*WIDTH  unreduced product; captured when in_valid && in_ready
//  in_valid   in   1        ab valid
//  in_ready   out  1        block idle, accepts a new product
//  r          out  WIDTH    ab mod P; meaningful only while out_valid
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        downstream accepts r
// BEHAVIOUR
//  Reset (reset==0 at a clk edge) forces:
//   - state IDLE; in_ready=1, out_valid=0, r='0
//   - acc='0, cnt='0
//  State IDLE (in_ready=1):
//   - on in_valid: shreg<=ab, acc<=0, cnt<=2*WIDTH-1, goto RUN
//  State RUN (in_ready=0, out_valid=0):
//   - each cycle t[WIDTH:0] = {acc,shreg[MSB]}
//   - acc <= (t>=P) ? t-P : t
//   - shreg <<= 1, cnt--
//   - when cnt==0 this cycle, goto DONE
//  State DONE (out_valid=1, r=acc):
//   - on out_ready goto IDLE; in_ready rises the following cycle (no same-cycle bypass)
//   - r stable while out_valid && !out_ready
//  Latency and throughput:
//   - 2*WIDTH RUN cycles; out_valid first high 2*WIDTH+1 cycles after the accept edge
//   - one product in flight
//  Arithmetic:
//   - invariant acc<P, so one conditional subtract per bit suffices; t is WIDTH+1 bits
//   - any ab < 2**(2*WIDTH) is legal, including ab >= P*P
//  Boundaries:
//   - ab=0 -> r=0; ab=P -> r=0; ab=P-1 -> r=P-1
//   - in_valid while busy is ignored (in_ready=0); upstream holds its data
//   - reset mid-RUN or mid-DONE aborts silently; no partial result is emitted
// CONFIGURATION
//  REDUCE_RADIX4_EN
//   - defined: 2 bits/cycle
//     - t[WIDTH+1:0] = {acc,shreg[MSB:MSB-1]}
//     - subtract the largest of {3P,2P,P,0} not exceeding t
//     - shreg <<= 2; cnt starts at WIDTH-1
//     - latency WIDTH+1 (378 default)
//   - undefined: radix-2 as above, latency 2*WIDTH+1 (755 default)
//   - ports and handshake are identical in both builds
// STRUCTURE
//  Package elliptic_curve_structs:
//   - P_WIDTH and params.p already live there
//   - add typedef fe_t = logic[P_WIDTH-1:0]
//   - add typedef prod_t = logic[2*P_WIDTH-1:0]
//  Local constants P2=2*P, P3=3*P, derived inside the block.
//  Sub-module mod_sub_step: combinational compare/conditional-subtract of t against P (and 2P/3P under
//  REDUCE_RADIX4_EN). Instantiated once; the FSM, shift register and counter stay in mod_p_reducer.
// TESTING
//  1. Small config (WIDTH=4, P=13):
//     - ab=8'hFF -> r=8
//     - ab=8'h00 -> r=0
//     - ab=8'h0D -> r=0
//     - ab=8'h0C -> r=12
//  2. Latency, WIDTH=4:
//     - out_valid rises exactly 9 cycles after the accept edge (5 with REDUCE_RADIX4_EN)
//     - in_ready=0 throughout
//  3. Full width:
//     - a=377'h1647170e...3eb11, b=377'h144b5478...8f416, ab=a*b
//     - r must equal (a*b)%params.p from the bench model
//     - latency 755 (378 with macro)
//  4. Backpressure:
//     - hold out_ready=0 for 10 cycles after out_valid
//     - r and out_valid stay constant
//     - out_ready=1 -> out_valid=0 next cycle, in_ready=1 the cycle after
//  5. Busy and back-to-back:
//     - pulse in_valid with a new ab during RUN -> ignored, first result unaffected
//     - tie in_valid high -> two products reduced back-to-back, both correct, in order
//  6. Reset mid-operation:
//     - reset=0 for one cycle, 100 cycles into RUN
//     - next cycle: out_valid=0, in_ready=1
//     - a fresh ab=P-1 then yields r=P-1

Source files
------------

// File: rtl/mod_p_reducer_pkg.sv
// Shared field constants and types for the field-multiply path.
// REDUCE_RADIX4_EN selects two reduction bits per cycle instead of one.
package elliptic_curve_structs;

    localparam int P_WIDTH = 377;

    typedef struct packed {
        logic [P_WIDTH-1:0] p;
    } params_t;

    // BLS12-377 base field modulus
    localparam params_t params = '{
        p: 377'h1ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001
    };

    typedef logic [P_WIDTH-1:0]   fe_t;
    typedef logic [2*P_WIDTH-1:0] prod_t;

`ifdef REDUCE_RADIX4_EN
    localparam int RED_STEP = 2;
`else
    localparam int RED_STEP = 1;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mod_p_reducer_if.sv
// Product-in / residue-out handshake bundle for mod_p_reducer.
interface mod_p_reducer_if import elliptic_curve_structs::*; #(
    parameter int WIDTH = P_WIDTH
);
    // A transfer on either side happens on a rising clk edge where valid && ready;
    // the source holds its data and valid until that edge, ready may not depend on valid.
    logic [2*WIDTH-1:0] ab;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   r;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output ab, in_valid, out_ready,
        input  in_ready, r, out_valid
    );

    modport slave (
        input  ab, in_valid, out_ready,
        output in_ready, r, out_valid
    );
endinterface

// File: rtl/mod_p_reducer_sub.sv
// Combinational conditional subtract: folds t back below P.
// Under REDUCE_RADIX4_EN t < 4P, so the largest of 3P/2P/P not above t is removed.
module mod_sub_step import elliptic_curve_structs::*; #(
    parameter int               WIDTH = P_WIDTH,
    parameter logic [WIDTH-1:0] P     = params.p
) (
    input  logic [WIDTH+RED_STEP-1:0] t,
    output logic [WIDTH-1:0]          res
);
    localparam logic [WIDTH+RED_STEP-1:0] P1 = {{RED_STEP{1'b0}}, P};

    // The result is below P, so subtracting only the low WIDTH bits is exact.
`ifdef REDUCE_RADIX4_EN
    localparam logic [WIDTH+RED_STEP-1:0] P2 = P1 << 1;
    localparam logic [WIDTH+RED_STEP-1:0] P3 = P1 + P2;

    always_comb begin
        res = t[WIDTH-1:0];
        if (t >= P3)      res = t[WIDTH-1:0] - P3[WIDTH-1:0];
        else if (t >= P2) res = t[WIDTH-1:0] - P2[WIDTH-1:0];
        else if (t >= P1) res = t[WIDTH-1:0] - P;
    end
`else
    always_comb begin
        res = t[WIDTH-1:0];
        if (t >= P1) res = t[WIDTH-1:0] - P;
    end
`endif
endmodule

// File: rtl/mod_p_reducer.sv
// Interleaved MSB-first reduction of a 2*WIDTH-bit product modulo P.
// REDUCE_RADIX4_EN consumes two product bits per cycle (half the latency).
module mod_p_reducer import elliptic_curve_structs::*; #(
    parameter int               WIDTH = P_WIDTH,
    parameter logic [WIDTH-1:0] P     = params.p
) (
    input  logic          clk,
    input  logic          reset,
    mod_p_reducer_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int             PW        = 2 * WIDTH;
    localparam int             CW        = $clog2(PW);
    localparam logic [CW-1:0]  CNT_START = CW'(PW / RED_STEP - 1);

    logic [1:0]              state;
    logic [PW-1:0]           shreg;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        acc_next;
    logic [CW-1:0]           cnt;
    logic [WIDTH+RED_STEP-1:0] t;

    // acc < P holds between steps, so t stays below 2**RED_STEP * P.
    assign t = {acc, shreg[PW-1 -: RED_STEP]};

    mod_sub_step #(.WIDTH(WIDTH), .P(P)) u_step (
        .t   (t),
        .res (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        shreg <= bus.ab;
                        acc   <= '0;
                        cnt   <= CNT_START;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg << RED_STEP;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    // Partial accumulator values are never exposed on r.
    assign bus.r         = (state == ST_DONE) ? acc : '0;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mod_p_reducer.sv
// Bench for mod_p_reducer: a WIDTH=4/P=13 instance and a full-width BLS12-377 instance.
// Expected residues are queued at accept time and popped on each output handshake.
module tb_mod_p_reducer;
    import elliptic_curve_structs::*;

    localparam int         SW = 4;
    localparam logic [3:0] SP = 4'd13;
`ifdef REDUCE_RADIX4_EN
    localparam int LAT_S = SW + 1;
    localparam int LAT_F = P_WIDTH + 1;
`else
    localparam int LAT_S = 2 * SW + 1;
    localparam int LAT_F = 2 * P_WIDTH + 1;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_s;
    logic [1:0] dbg_f;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] exp_s_q[$];
    fe_t           exp_f_q[$];

    always #5 clk = ~clk;

    mod_p_reducer_if #(.WIDTH(SW))      bus_s ();
    mod_p_reducer_if #(.WIDTH(P_WIDTH)) bus_f ();

    mod_p_reducer #(.WIDTH(SW), .P(SP)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_s.slave),
        .dbg_state (dbg_s)
    );

    mod_p_reducer #(.WIDTH(P_WIDTH), .P(params.p)) dut_f (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_f.slave),
        .dbg_state (dbg_f)
    );

    task automatic check(input string tag, input fe_t got, input fe_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Output-side scoreboards: compare on the edge where the handshake completes.
    always @(negedge clk) begin
        if (reset && bus_s.out_valid && bus_s.out_ready) begin
            if (exp_s_q.size() == 0) check("s_q_size", fe_t'(exp_s_q.size()), fe_t'(1));
            else                     check("s_r", fe_t'(bus_s.r), fe_t'(exp_s_q.pop_front()));
        end
        if (reset && bus_f.out_valid && bus_f.out_ready) begin
            if (exp_f_q.size() == 0) check("f_q_size", fe_t'(exp_f_q.size()), fe_t'(1));
            else                     check("f_r", bus_f.r, exp_f_q.pop_front());
        end
    end

    task automatic send_s(input logic [2*SW-1:0] ab, input logic [SW-1:0] exp, input bit hold);
        int n = 0;
        bus_s.ab       = ab;
        bus_s.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_s.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s_accept", fe_t'(bus_s.in_ready), fe_t'(1));
        exp_s_q.push_back(exp);
        @(posedge clk);
        #1;
        if (!hold) bus_s.in_valid = 1'b0;
    endtask

    task automatic send_f(input prod_t ab, input fe_t exp, input bit hold);
        int n = 0;
        bus_f.ab       = ab;
        bus_f.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_f.in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("f_accept", fe_t'(bus_f.in_ready), fe_t'(1));
        exp_f_q.push_back(exp);
        @(posedge clk);
        #1;
        if (!hold) bus_f.in_valid = 1'b0;
    endtask

    // Called right after the accept edge; the accept edge itself counts as cycle 1.
    task automatic latency_s(input string tag);
        int n = 1;
        bit busy_ok = 1'b1;
        while (!bus_s.out_valid && n < 3000) begin
            if (bus_s.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, fe_t'(n), fe_t'(LAT_S));
        check({tag, "_busy"}, fe_t'(busy_ok), fe_t'(1));
    endtask

    task automatic latency_f(input string tag);
        int n = 1;
        bit busy_ok = 1'b1;
        while (!bus_f.out_valid && n < 3000) begin
            if (bus_f.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, fe_t'(n), fe_t'(LAT_F));
        check({tag, "_busy"}, fe_t'(busy_ok), fe_t'(1));
    endtask

    task automatic drain_s();
        int n = 0;
        while (exp_s_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("s_drain", fe_t'(exp_s_q.size()), fe_t'(0));
    endtask

    task automatic drain_f();
        int n = 0;
        while (exp_f_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("f_drain", fe_t'(exp_f_q.size()), fe_t'(0));
    endtask

    function automatic fe_t rand_fe();
        fe_t v = '0;
        for (int i = 0; i < 12; i++) v = (v << 32) | fe_t'($urandom);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0]    tbl_ab[4];
        logic [SW-1:0] tbl_r[4];
        logic [7:0]    sab;
        logic [SW-1:0] r0;
        bit            stable;
        int            n;
        fe_t           a;
        fe_t           b;
        prod_t         ab;

        tbl_ab = '{8'hFF, 8'h00, 8'h0D, 8'h0C};
        tbl_r  = '{4'd8, 4'd0, 4'd0, 4'd12};

        bus_s.ab = '0; bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1;
        bus_f.ab = '0; bus_f.in_valid = 1'b0; bus_f.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_in_ready",  fe_t'(bus_s.in_ready),  fe_t'(1));
        check("rst_s_out_valid", fe_t'(bus_s.out_valid), fe_t'(0));
        check("rst_s_r",         fe_t'(bus_s.r),         fe_t'(0));
        check("rst_s_state",     fe_t'(dbg_s),           fe_t'(ST_IDLE));
        check("rst_f_in_ready",  fe_t'(bus_f.in_ready),  fe_t'(1));
        check("rst_f_out_valid", fe_t'(bus_f.out_valid), fe_t'(0));
        check("rst_f_r",         bus_f.r,                fe_t'(0));
        reset = 1'b1;

        // Small-config reference points
        for (int i = 0; i < 4; i++) begin
            send_s(tbl_ab[i], tbl_r[i], 1'b0);
            drain_s();
        end

        send_s(8'hA7, SW'(8'hA7 % 8'd13), 1'b0);
        latency_s("s_latency");
        drain_s();

        for (int i = 0; i < 6; i++) begin
            sab = 8'($urandom_range(0, 255));
            send_s(sab, SW'(sab % 8'd13), 1'b0);
            drain_s();
        end

        // Backpressure: result must hold until out_ready
        bus_s.out_ready = 1'b0;
        send_s(8'hB5, SW'(8'hB5 % 8'd13), 1'b0);
        n = 0;
        while (!bus_s.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid", fe_t'(bus_s.out_valid), fe_t'(1));
        r0 = bus_s.r;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus_s.r !== r0 || bus_s.out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", fe_t'(stable), fe_t'(1));
        check("bp_no_bypass", fe_t'(bus_s.in_ready), fe_t'(0));
        bus_s.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_drop", fe_t'(bus_s.out_valid), fe_t'(0));
        check("bp_in_ready_rise",  fe_t'(bus_s.in_ready),  fe_t'(1));
        drain_s();

        // in_valid pulse while busy must be ignored
        send_s(8'h6B, SW'(8'h6B % 8'd13), 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus_s.ab       = 8'hFF;
        bus_s.in_valid = 1'b1;
        check("busy_in_ready", fe_t'(bus_s.in_ready), fe_t'(0));
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        drain_s();
        repeat (30) @(posedge clk);
        #1;
        check("busy_idle", fe_t'(bus_s.in_ready), fe_t'(1));

        // Back-to-back with in_valid held high
        send_s(8'hE3, SW'(8'hE3 % 8'd13), 1'b1);
        send_s(8'h5A, SW'(8'h5A % 8'd13), 1'b0);
        drain_s();

        // Full-width boundaries
        send_f(prod_t'(0), fe_t'(0), 1'b0);
        drain_f();
        send_f(prod_t'(params.p), fe_t'(0), 1'b0);
        drain_f();
        send_f(prod_t'(params.p - 1'b1), params.p - 1'b1, 1'b0);
        drain_f();
        ab = '1;
        send_f(ab, fe_t'(ab % prod_t'(params.p)), 1'b0);
        drain_f();

        // Full-width products a*b
        for (int i = 0; i < 2; i++) begin
            a  = rand_fe();
            b  = rand_fe();
            ab = prod_t'(a) * prod_t'(b);
            send_f(ab, fe_t'(ab % prod_t'(params.p)), 1'b0);
            if (i == 0) latency_f("f_latency");
            drain_f();
        end

        // Reset 100 cycles into RUN aborts without output
        a  = rand_fe();
        b  = rand_fe();
        ab = prod_t'(a) * prod_t'(b);
        send_f(ab, fe_t'(ab % prod_t'(params.p)), 1'b0);
        repeat (99) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_f_q.delete();
        check("mid_rst_out_valid", fe_t'(bus_f.out_valid), fe_t'(0));
        check("mid_rst_in_ready",  fe_t'(bus_f.in_ready),  fe_t'(1));
        check("mid_rst_state",     fe_t'(dbg_f),           fe_t'(ST_IDLE));
        send_f(prod_t'(params.p - 1'b1), params.p - 1'b1, 1'b0);
        latency_f("f_latency_after_rst");
        drain_f();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
